div: RTL and testbench



---
 rtl/div_if.sv | 20 ++
 rtl/div.sv | 113 +++++++++++
 tb/tb_div.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
interface div_if;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/div.sv
// Iterative restoring 32-bit DIV/DIVU, one quotient bit per cycle, result {rem, quot}.
// Optional DIV_EARLY_EXIT_EN: skip iteration when |dividend| < |divisor|.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    logic [1:0]  state_reg;
    logic [5:0]  cnt_reg;
    logic [64:0] work_reg;
    logic [31:0] divisor_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [63:0] result_reg;
    logic        ready_reg;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    always_comb begin
        mag1  = (bus.signed_div && bus.opdata1[31]) ? (~bus.opdata1 + 32'd1) : bus.opdata1;
        mag2  = (bus.signed_div && bus.opdata2[31]) ? (~bus.opdata2 + 32'd1) : bus.opdata2;
        diff  = {1'b0, work_reg[63:32]} - {1'b0, divisor_reg};
        q_fix = neg_q_reg ? (~work_reg[31:0] + 32'd1) : work_reg[31:0];
        r_fix = neg_r_reg ? (~work_reg[64:33] + 32'd1) : work_reg[64:33];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DIV_FREE;
            cnt_reg     <= 6'd0;
            work_reg    <= 65'd0;
            divisor_reg <= 32'd0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            result_reg  <= 64'd0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                DIV_FREE: begin
                    result_reg <= 64'd0;
                    ready_reg  <= 1'b0;
                    if (bus.start && !bus.annul) begin
                        if (bus.opdata2 == 32'd0) begin
                            state_reg <= DIV_BY_ZERO;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (mag1 < mag2) begin
                            // Quotient 0, remainder is the untouched signed dividend.
                            work_reg  <= {bus.opdata1, 33'd0};
                            state_reg <= DIV_END;
`endif
                        end else begin
                            divisor_reg <= mag2;
                            work_reg    <= {32'd0, mag1, 1'b0};
                            cnt_reg     <= 6'd0;
                            neg_q_reg   <= bus.signed_div && (bus.opdata1[31] ^ bus.opdata2[31]);
                            neg_r_reg   <= bus.signed_div && bus.opdata1[31];
                            state_reg   <= DIV_ON;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (bus.annul) begin
                        state_reg <= DIV_FREE;
                    end else begin
                        work_reg  <= 65'd0;
                        state_reg <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (bus.annul || !bus.start) begin
                        state_reg  <= DIV_FREE;
                        cnt_reg    <= 6'd0;
                        result_reg <= 64'd0;
                        ready_reg  <= 1'b0;
                    end else if (cnt_reg != 6'd32) begin
                        // Restoring step: keep the difference only if it did not borrow.
                        if (diff[32])
                            work_reg <= {work_reg[63:0], 1'b0};
                        else
                            work_reg <= {diff[31:0], work_reg[31:0], 1'b1};
                        cnt_reg <= cnt_reg + 6'd1;
                    end else begin
                        work_reg  <= {r_fix, work_reg[32], q_fix};
                        cnt_reg   <= 6'd0;
                        state_reg <= DIV_END;
                    end
                end
                default: begin
                    if (bus.start) begin
                        result_reg <= {work_reg[64:33], work_reg[31:0]};
                        ready_reg  <= 1'b1;
                    end else begin
                        state_reg  <= DIV_FREE;
                        result_reg <= 64'd0;
                        ready_reg  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.ready  = ready_reg;
endmodule

// File: tb/tb_div.sv
// Directed and reference-model checks for the iterative divider.
module tb_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    div_if bus ();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // Drives one request, scrambles operands after acceptance, holds start one
    // extra cycle after ready, then drops start.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat,
                           output logic held, output logic dropped);
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        lat = 0;
        @(posedge clk); #1;
        bus.opdata1 = ~a;
        bus.opdata2 = b + 32'd3;
        bus.signed_div = ~sgn;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (bus.ready) begin
                lat = c;
                break;
            end
        end
        res = bus.result;
        @(posedge clk); #1;
        held = bus.ready && (bus.result == res);
        bus.start = 1'b0;
        @(posedge clk); #1;
        dropped = !bus.ready && (bus.result == 64'd0);
    endtask

    task automatic test_reset();
        bus.signed_div = 1'b0;
        bus.opdata1 = 32'd0;
        bus.opdata2 = 32'd0;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", bus.ready);
        end
        total++;
        if (bus.result !== 64'd0) begin
            bad++;
            $display("FAIL reset_result got=%h want=0", bus.result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [63:0] res;
        int lat;
        logic held, dropped;
        logic        sg[6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] av[6]   = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234, 32'd3, 32'd7};
        logic [31:0] bv[6]   = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd9, 32'hFFFF_FFFE};
        logic [63:0] ev[6]   = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                                 64'h00000000_80000000, 64'h0, 64'h00000003_00000000,
                                 64'h00000001_FFFFFFFD};
        int          lv[6]   = '{34, 34, 34, 2, EARLY ? 1 : 34, 34};
        for (int i = 0; i < 6; i++) begin
            run_div(sg[i], av[i], bv[i], res, lat, held, dropped);
            total++;
            if (lat !== lv[i]) begin
                bad++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, lv[i]);
            end
            total++;
            if (res !== ev[i]) begin
                bad++;
                $display("FAIL dir%0d_result got=%h want=%h", i, res, ev[i]);
            end
            total++;
            if (held !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_hold got=%b want=1", i, held);
            end
            total++;
            if (dropped !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_drop got=%b want=1", i, dropped);
            end
            $display("dir%0d sgn=%b a=%h b=%h res=%h lat=%0d", i, sg[i], av[i], bv[i], res, lat);
        end
    endtask

    // Abort mid-division by annul (use_rst=0) or reset (use_rst=1), then redo.
    task automatic test_abort(input logic use_rst);
        logic [63:0] res;
        int lat;
        logic held, dropped, seen;
        bus.signed_div = 1'b0;
        bus.opdata1 = 32'd1000;
        bus.opdata2 = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1; else bus.annul = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.annul = 1'b0;
        bus.start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort%0d_ready got=%b want=0", use_rst, seen);
        end
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, res, lat, held, dropped);
        total++;
        if (res !== 64'hFFFFFFFE_FFFFFFF2 || lat !== 34) begin
            bad++;
            $display("FAIL abort%0d_redo got=%h/%0d want=fffffffefffffff2/34", use_rst, res, lat);
        end
        $display("abort%0d redo res=%h lat=%0d", use_rst, res, lat);
    endtask

    task automatic test_random();
        logic [63:0] res;
        int lat, elat;
        logic held, dropped;
        logic sgn;
        logic [31:0] a, b, q, r, ma, mb;
        for (int i = 0; i < 150; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = (i % 4 == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 60)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
            if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
            end else begin
                q = a / b;
                r = a % b;
                ma = a;
                mb = b;
            end
            elat = (EARLY && ma < mb) ? 1 : 34;
            run_div(sgn, a, b, res, lat, held, dropped);
            total++;
            if (res !== {r, q} || res[31:0] * b + res[63:32] !== a) begin
                bad++;
                $display("FAIL rnd%0d_result sgn=%b a=%h b=%h got=%h want=%h", i, sgn, a, b, res, {r, q});
            end
            total++;
            if (lat !== elat || !dropped) begin
                bad++;
                $display("FAIL rnd%0d_timing got=%0d/%b want=%0d/1", i, lat, dropped, elat);
            end
            $display("rnd%0d sgn=%b a=%h b=%h res=%h lat=%0d", i, sgn, a, b, res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
